div_repeated_sub: RTL and testbench



---
 rtl/div_pkg.sv | 20 ++
 rtl/sub_w.sv | 19 +
 rtl/div_repeated_sub.sv | 108 ++++++++++
 tb/tb_div_repeated_sub.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
//   Shared definitions for the repeated-subtraction divider.
//   - DIV_WIDTH : default operand/result width
//   - state_e   : divider FSM states
//   - QUOT_DZ   : quotient reported for a zero divisor (all ones)
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

    localparam logic [DIV_WIDTH-1:0] QUOT_DZ = '1;

endpackage : div_pkg

// File: rtl/sub_w.sv
// -----------------------------------------------------------------------------
// sub_w
//   Combinational WIDTH-bit unsigned subtractor, out_o = in1_i - in2_i.
//   Ports:
//     in1_i [WIDTH] minuend
//     in2_i [WIDTH] subtrahend
//     out_o [WIDTH] difference (modulo 2^WIDTH)
// -----------------------------------------------------------------------------
module sub_w #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] in1_i,
    input  logic [WIDTH-1:0] in2_i,
    output logic [WIDTH-1:0] out_o
);

    assign out_o = in1_i - in2_i;

endmodule : sub_w

// File: rtl/div_repeated_sub.sv
// -----------------------------------------------------------------------------
// div_repeated_sub
//   Sequential unsigned divider. Operands are latched on start; the divisor is
//   subtracted from a running remainder once per clock while it still fits,
//   and the iteration count becomes the quotient.
//   Ports:
//     clk          system clock, rising edge
//     rst_n        asynchronous active-low reset
//     start        request, sampled only while idle
//     dividend     [WIDTH] unsigned dividend, sampled with start
//     divisor      [WIDTH] unsigned divisor, sampled with start
//     busy         high from the accepting edge until the return to idle
//     done         one-cycle completion pulse
//     quotient     [WIDTH] result, held until the next completion
//     remainder    [WIDTH] result, held until the next completion
//     div_by_zero  error flag, held until the next completion
// -----------------------------------------------------------------------------
module div_repeated_sub
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    state_e           state_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] cnt_q;
    logic             dz_q;

    logic [WIDTH-1:0] rem_d;
    logic             rem_ge_div;

    sub_w #(
        .WIDTH(WIDTH)
    ) u_sub (
        .in1_i(rem_q),
        .in2_i(div_q),
        .out_o(rem_d)
    );

    // Subtraction result is only used when this holds, so it never borrows.
    assign rem_ge_div = (rem_q >= div_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            div_q       <= '0;
            cnt_q       <= '0;
            dz_q        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        rem_q   <= dividend;
                        div_q   <= divisor;
                        cnt_q   <= '0;
                        dz_q    <= (divisor == '0);
                        busy    <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    // A zero divisor would always "fit"; the marker sends it
                    // straight on after one cycle, so done lands two edges
                    // after acceptance, the same as a zero-quotient divide.
                    if (dz_q || !rem_ge_div) begin
                        state_q <= FIN;
                    end else begin
                        rem_q <= rem_d;
                        cnt_q <= cnt_q + WIDTH'(1);
                    end
                end
                FIN: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= IDLE;
                    // rem_q still holds the latched dividend on a zero divide.
                    remainder   <= rem_q;
                    div_by_zero <= dz_q;
                    quotient    <= dz_q ? {WIDTH{1'b1}} : cnt_q;
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule : div_repeated_sub

// File: tb/tb_div_repeated_sub.sv
module tb_div_repeated_sub;
    import div_pkg::*;

    localparam int W = DIV_WIDTH;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           due;
    } exp_t;

    exp_t sb[$];

    div_repeated_sub #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient),
        .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int e);
        exp_t x;
        if (b == '0) begin
            x.q = QUOT_DZ; x.r = a; x.dz = 1'b1; x.due = e + 2;
        end else begin
            x.q = a / b; x.r = a % b; x.dz = 1'b0; x.due = e + int'(a / b) + 2;
        end
        return x;
    endfunction

    // Pulse start for one cycle and record the expected result; returns the
    // accepting edge number. Leaves the caller at the negedge after that edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, output int e);
        @(negedge clk);
        dividend = a; divisor = b; start = 1'b1;
        e = cyc + 1;
        sb.push_back(model(a, b, e));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok, output int at);
        ok = 1'b0; at = -1;
        for (int i = 0; i < budget; i++) begin
            if (done === 1'b1) begin ok = 1'b1; at = cyc; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b q=%h r=%h dz=%b, want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        rst_n = 1'b1;
    endtask

    // Wait for the oldest outstanding request and compare everything about it.
    task automatic finish_one(input string name, input int budget);
        bit ok; int at; exp_t x;
        wait_done(budget, ok, at);
        x = sb.pop_front();
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
            return;
        end
        checks++;
        if (at !== x.due) begin
            errors++; $display("FAIL %s_latency: done after edge %0d, want %0d", name, at, x.due);
        end
        checks++;
        if (quotient !== x.q || remainder !== x.r || div_by_zero !== x.dz) begin
            errors++;
            $display("FAIL %s_result: got q=%h r=%h dz=%b, want q=%h r=%h dz=%b",
                     name, quotient, remainder, div_by_zero, x.q, x.r, x.dz);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL %s_busy_at_done: got %b, want 0", name, busy);
        end
    endtask

    task automatic check_pulse_end(input string name);
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL %s_done_width: done still %b one cycle later, want 0", name, done);
        end
    endtask

    task automatic test_basic();
        int e;
        issue(16'd100, 16'd7, e);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL basic_busy: got busy=%b done=%b, want 1 0", busy, done);
        end
        finish_one("basic_100_7", 40);
        check_pulse_end("basic_100_7");
    endtask

    task automatic test_small();
        int e;
        issue(16'd5, 16'd9, e);
        finish_one("small_5_9", 20);
        issue(16'd0, 16'd3, e);
        finish_one("zero_dividend", 20);
    endtask

    task automatic test_div_zero();
        int e;
        issue(16'd42, 16'd0, e);
        finish_one("div_zero", 20);
        check_pulse_end("div_zero");
        issue(16'd42, 16'd6, e);
        finish_one("after_div_zero", 30);
    endtask

    task automatic test_worst_case();
        int e;
        issue(16'hFFFF, 16'd1, e);
        finish_one("worst_case", 70000);
    endtask

    task automatic test_ignored_start();
        int e;
        issue(16'd100, 16'd7, e);
        while (cyc < e + 4) @(negedge clk);
        dividend = 16'd9; divisor = 16'd3; start = 1'b1;   // sampled at E+5
        @(negedge clk);
        start = 1'b0;
        finish_one("ignored_start", 40);
    endtask

    task automatic test_back_to_back();
        int e; bit ok; int at;
        issue(16'd100, 16'd7, e);
        wait_done(40, ok, at);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL b2b_first_timeout: no done within 40 cycles");
        end
        // Still in the done cycle: present the next request now.
        dividend = 16'd9; divisor = 16'd3; start = 1'b1;
        void'(sb.pop_front());
        sb.push_back(model(16'd9, 16'd3, cyc + 1));
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || quotient !== 16'd14 || remainder !== 16'd2) begin
            errors++;
            $display("FAIL b2b_accept_hold: got busy=%b q=%0d r=%0d, want busy=1 q=14 r=2",
                     busy, quotient, remainder);
        end
        finish_one("b2b_9_3", 20);
    endtask

    task automatic test_reset_abort();
        int e; bit saw_done;
        issue(16'd1000, 16'd3, e);
        while (cyc < e + 19) @(negedge clk);
        saw_done = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL abort_outputs: got busy=%b done=%b q=%h r=%h dz=%b, want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        void'(sb.pop_front());
        repeat (2) begin
            @(negedge clk);
            if (done !== 1'b0) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        repeat (400) begin
            @(negedge clk);
            if (done !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++; $display("FAIL abort_no_done: done pulse seen after reset abort, want none");
        end
        issue(16'd10, 16'd4, e);
        finish_one("after_abort", 20);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_small();
        test_div_zero();
        test_ignored_start();
        test_back_to_back();
        test_reset_abort();
        test_worst_case();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_div_repeated_sub
